// File: rtl/wmem_pingpong_pkg.sv
// -----------------------------------------------------------------------------
// wmem_pkg
// Shared constants and types for the ping-pong weight memory.
//   DATA_WIDTH_DEF / ROW_NUM_DEF / ADDR_WIDTH_DEF : default geometry
//   NUM_BANKS  : number of ping-pong banks (always 2)
//   row_wgt_t  : one row-weight word at the default geometry
//   full_count : population count of the two bank-full flags
// -----------------------------------------------------------------------------
package wmem_pkg;

  localparam int DATA_WIDTH_DEF    = 8;
  localparam int ROW_NUM_DEF       = 6;
  localparam int ADDR_WIDTH_DEF    = 7;
  localparam int NUM_BANKS         = 2;
  localparam int ROW_WGT_WIDTH_DEF = DATA_WIDTH_DEF * ROW_NUM_DEF;

  typedef logic [ROW_WGT_WIDTH_DEF-1:0] row_wgt_t;

  // Number of full banks, 0..2.
  function automatic logic [1:0] full_count(input logic [NUM_BANKS-1:0] full);
    return {1'b0, full[0]} + {1'b0, full[1]};
  endfunction

endpackage

// File: rtl/wmem_pingpong_if.sv
// -----------------------------------------------------------------------------
// wmem_pingpong_if
// Writer/reader bus of the ping-pong weight memory.
//   write side : i_wr_en, i_wr_addr, i_wr_data, i_wr_done -> o_wr_ready
//   read side  : i_rd_en, i_rd_addr, i_rd_done -> o_rd_data, o_rd_valid,
//                o_rd_ready
//   status     : o_wr_bank, o_rd_bank, o_full_cnt
// The slave modport belongs to the memory; master belongs to the user.
// -----------------------------------------------------------------------------
interface wmem_pingpong_if #(
  parameter int DATA_WIDTH = wmem_pkg::DATA_WIDTH_DEF,
  parameter int ROW_NUM    = wmem_pkg::ROW_NUM_DEF,
  parameter int ADDR_WIDTH = wmem_pkg::ADDR_WIDTH_DEF
);

  localparam int ROW_WGT_WIDTH = DATA_WIDTH * ROW_NUM;

  logic                     i_wr_en;
  logic [ADDR_WIDTH-1:0]    i_wr_addr;
  logic [ROW_WGT_WIDTH-1:0] i_wr_data;
  logic                     i_wr_done;
  logic                     o_wr_ready;
  logic                     i_rd_en;
  logic [ADDR_WIDTH-1:0]    i_rd_addr;
  logic [ROW_WGT_WIDTH-1:0] o_rd_data;
  logic                     o_rd_valid;
  logic                     i_rd_done;
  logic                     o_rd_ready;
  logic                     o_wr_bank;
  logic                     o_rd_bank;
  logic [1:0]               o_full_cnt;

  modport slave (
    input  i_wr_en, i_wr_addr, i_wr_data, i_wr_done,
    input  i_rd_en, i_rd_addr, i_rd_done,
    output o_wr_ready, o_rd_data, o_rd_valid, o_rd_ready,
    output o_wr_bank, o_rd_bank, o_full_cnt
  );

  modport master (
    output i_wr_en, i_wr_addr, i_wr_data, i_wr_done,
    output i_rd_en, i_rd_addr, i_rd_done,
    input  o_wr_ready, o_rd_data, o_rd_valid, o_rd_ready,
    input  o_wr_bank, o_rd_bank, o_full_cnt
  );

endinterface

// File: rtl/wmem_pingpong_bank.sv
// -----------------------------------------------------------------------------
// wmem_bank
// One weight bank: 2**ADDR_WIDTH words, synchronous write port and a
// registered read port whose output holds between reads.
//   i_clk, i_rst_n : clock, async active-low reset (read register only)
//   i_we, i_waddr, i_wdata : write port
//   i_re, i_raddr  : read request
//   o_rdata        : registered read word
// -----------------------------------------------------------------------------
module wmem_bank #(
  parameter int WIDTH      = wmem_pkg::ROW_WGT_WIDTH_DEF,
  parameter int ADDR_WIDTH = wmem_pkg::ADDR_WIDTH_DEF
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [WIDTH-1:0]      i_wdata,
  input  logic                  i_re,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [WIDTH-1:0]      o_rdata
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  // Storage array: no reset so it maps onto RAM; contents undefined until written.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Read register: captures on request, otherwise holds the last word.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rdata <= {WIDTH{1'b0}};
    end else if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end else begin
      r_rdata <= r_rdata;
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/wmem_pingpong.sv
// -----------------------------------------------------------------------------
// wmem_pingpong
// Double-buffered weight memory: the loader fills one bank while the PE array
// reads the other; ownership moves through wr_done / rd_done handshakes.
//   i_clk   : clock, rising edge
//   i_rst_n : asynchronous active-low reset
//   bus     : wmem_pingpong_if.slave (write, read, handshake and status)
// Ready/status outputs are decoded from registered state only.
// -----------------------------------------------------------------------------
module wmem_pingpong
  import wmem_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ROW_NUM    = ROW_NUM_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  localparam int ROW_WGT_WIDTH = DATA_WIDTH * ROW_NUM
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  wmem_pingpong_if.slave    bus
);

  logic [NUM_BANKS-1:0]     r_full;
  logic                     r_wr_ptr;
  logic                     r_rd_ptr;
  logic                     r_rd_valid;
  logic                     r_rd_sel;

  logic [NUM_BANKS-1:0]     w_full_nxt;
  logic                     w_wr_ptr_nxt;
  logic                     w_rd_ptr_nxt;
  logic                     w_wr_ready;
  logic                     w_rd_ready;
  logic                     w_wr_fire;
  logic                     w_rd_fire;
  logic [NUM_BANKS-1:0]     w_bank_we;
  logic [NUM_BANKS-1:0]     w_bank_re;
  logic [ROW_WGT_WIDTH-1:0] w_bank_rdata [NUM_BANKS];

  // Handshake decode: acceptance of writes, reads and both done pulses.
  always_comb begin
    w_full_nxt   = r_full;
    w_wr_ptr_nxt = r_wr_ptr;
    w_rd_ptr_nxt = r_rd_ptr;
    w_wr_ready   = ~r_full[r_wr_ptr];
    w_rd_ready   = r_full[r_rd_ptr];
    w_wr_fire    = bus.i_wr_en & w_wr_ready;
    w_rd_fire    = bus.i_rd_en & w_rd_ready;
    // When both dones are accepted they name different banks, so the
    // set and the clear never collide and the full count is unchanged.
    if (bus.i_wr_done && w_wr_ready) begin
      w_full_nxt[r_wr_ptr] = 1'b1;
      w_wr_ptr_nxt         = ~r_wr_ptr;
    end else begin
      w_wr_ptr_nxt         = r_wr_ptr;
    end
    if (bus.i_rd_done && w_rd_ready) begin
      w_full_nxt[r_rd_ptr] = 1'b0;
      w_rd_ptr_nxt         = ~r_rd_ptr;
    end else begin
      w_rd_ptr_nxt         = r_rd_ptr;
    end
  end

  // Per-bank strobes: a same-cycle write or read still targets the old bank.
  always_comb begin
    w_bank_we = {NUM_BANKS{1'b0}};
    w_bank_re = {NUM_BANKS{1'b0}};
    for (int b = 0; b < NUM_BANKS; b++) begin
      w_bank_we[b] = w_wr_fire & (r_wr_ptr == b[0]);
      w_bank_re[b] = w_rd_fire & (r_rd_ptr == b[0]);
    end
  end

  // Ownership state, read-valid flag and the bank that produced the last read.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_full     <= {NUM_BANKS{1'b0}};
      r_wr_ptr   <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_sel   <= 1'b0;
    end else begin
      r_full     <= w_full_nxt;
      r_wr_ptr   <= w_wr_ptr_nxt;
      r_rd_ptr   <= w_rd_ptr_nxt;
      r_rd_valid <= w_rd_fire;
      // o_rd_data must hold between reads, so remember whose register to show.
      r_rd_sel   <= w_rd_fire ? r_rd_ptr : r_rd_sel;
    end
  end

  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
    wmem_bank #(
      .WIDTH      (ROW_WGT_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
    ) u_bank (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_we    (w_bank_we[g]),
      .i_waddr (bus.i_wr_addr),
      .i_wdata (bus.i_wr_data),
      .i_re    (w_bank_re[g]),
      .i_raddr (bus.i_rd_addr),
      .o_rdata (w_bank_rdata[g])
    );
  end

  assign bus.o_wr_ready = w_wr_ready;
  assign bus.o_rd_ready = w_rd_ready;
  assign bus.o_rd_valid = r_rd_valid;
  assign bus.o_rd_data  = w_bank_rdata[r_rd_sel];
  assign bus.o_wr_bank  = r_wr_ptr;
  assign bus.o_rd_bank  = r_rd_ptr;
  assign bus.o_full_cnt = full_count(r_full);

endmodule

// File: tb/tb_wmem_pingpong.sv
// -----------------------------------------------------------------------------
// tb_wmem_pingpong
// Directed and random stimulus for wmem_pingpong, checked against a
// reference model that tracks handoff/release counts and per-bank contents.
// -----------------------------------------------------------------------------
module tb_wmem_pingpong;

  localparam int AW = 7;
  localparam int DW = 48;

  logic clk;
  logic rst_n;

  wmem_pingpong_if bus ();

  wmem_pingpong dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: banks handed to the reader and banks released by it.
  int            m_hand;
  int            m_rel;
  logic [DW-1:0] m_mem   [2][128];
  bit            m_known [2][128];
  logic [DW-1:0] m_rd_data;
  bit            m_rd_known;
  bit            m_rd_valid;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk = n_chk + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_hand     = 0;
    m_rel      = 0;
    m_rd_data  = '0;
    m_rd_known = 1'b1;
    m_rd_valid = 1'b0;
  endtask

  task automatic model_step();
    int  cnt;
    int  wb;
    int  rb;
    bit  wr_rdy;
    bit  rd_rdy;
    cnt    = m_hand - m_rel;
    wr_rdy = (cnt < 2);
    rd_rdy = (cnt > 0);
    wb     = m_hand % 2;
    rb     = m_rel % 2;
    if (bus.i_rd_en && rd_rdy) begin
      m_rd_valid = 1'b1;
      m_rd_data  = m_mem[rb][bus.i_rd_addr];
      m_rd_known = m_known[rb][bus.i_rd_addr];
    end else begin
      m_rd_valid = 1'b0;
    end
    if (bus.i_wr_en && wr_rdy) begin
      m_mem[wb][bus.i_wr_addr]   = bus.i_wr_data;
      m_known[wb][bus.i_wr_addr] = 1'b1;
    end
    if (bus.i_wr_done && wr_rdy) m_hand = m_hand + 1;
    if (bus.i_rd_done && rd_rdy) m_rel = m_rel + 1;
  endtask

  task automatic check_all();
    int cnt;
    cnt = m_hand - m_rel;
    chk("wr_ready", 64'(bus.o_wr_ready), 64'(cnt < 2));
    chk("rd_ready", 64'(bus.o_rd_ready), 64'(cnt > 0));
    chk("full_cnt", 64'(bus.o_full_cnt), 64'(cnt));
    chk("wr_bank",  64'(bus.o_wr_bank),  64'(m_hand % 2));
    chk("rd_bank",  64'(bus.o_rd_bank),  64'(m_rel % 2));
    chk("rd_valid", 64'(bus.o_rd_valid), 64'(m_rd_valid));
    if (m_rd_known) chk("rd_data", 64'(bus.o_rd_data), 64'(m_rd_data));
  endtask

  task automatic drive(input bit we, input int wa, input logic [DW-1:0] wd, input bit wdn,
                       input bit re, input int ra, input bit rdn);
    bus.i_wr_en   = we;
    bus.i_wr_addr = wa[AW-1:0];
    bus.i_wr_data = wd;
    bus.i_wr_done = wdn;
    bus.i_rd_en   = re;
    bus.i_rd_addr = ra[AW-1:0];
    bus.i_rd_done = rdn;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  initial begin
    logic [63:0] rnd;
    for (int b = 0; b < 2; b++)
      for (int a = 0; a < 128; a++) begin
        m_mem[b][a]   = '0;
        m_known[b][a] = 1'b0;
      end
    model_reset();
    drive(1'b0, 0, 48'h0, 1'b0, 1'b0, 0, 1'b0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all();
    chk("rst_rd_data", 64'(bus.o_rd_data), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic fill of bank 0 and handoff
    for (int a = 0; a < 128; a++) begin
      drive(1'b1, a, 48'(a) * 48'h010101010101, 1'b0, 1'b0, 0, 1'b0);
      tick();
    end
    drive(1'b0, 0, 48'h0, 1'b1, 1'b0, 0, 1'b0);
    tick();
    chk("first_fill_rd_ready", 64'(bus.o_rd_ready), 64'h1);
    drive(1'b0, 0, 48'h0, 1'b0, 1'b1, 5, 1'b0);
    tick();
    chk("basic_rd_data", 64'(bus.o_rd_data), 64'h050505050505);
    chk("basic_rd_valid", 64'(bus.o_rd_valid), 64'h1);
    drive(1'b0, 0, 48'h0, 1'b0, 1'b0, 0, 1'b0);
    tick();
    chk("valid_one_cycle", 64'(bus.o_rd_valid), 64'h0);

    // Overlap: fill bank 1 while reading bank 0
    for (int a = 0; a < 128; a++) begin
      drive(1'b1, a, 48'hAAAAAAAAAAAA, 1'b0, 1'b1, 127 - a, 1'b0);
      tick();
    end
    drive(1'b0, 0, 48'h0, 1'b1, 1'b0, 0, 1'b0);
    tick();
    chk("overlap_full_cnt", 64'(bus.o_full_cnt), 64'h2);
    chk("overlap_wr_ready", 64'(bus.o_wr_ready), 64'h0);

    // Stall: write and done while both banks full are dropped
    drive(1'b1, 3, 48'hFFFFFFFFFFFF, 1'b1, 1'b0, 0, 1'b0);
    tick();
    chk("stall_full_cnt", 64'(bus.o_full_cnt), 64'h2);
    drive(1'b0, 0, 48'h0, 1'b0, 1'b0, 0, 1'b1);
    tick();
    chk("release_rd_bank", 64'(bus.o_rd_bank), 64'h1);
    chk("release_wr_ready", 64'(bus.o_wr_ready), 64'h1);
    drive(1'b0, 0, 48'h0, 1'b0, 1'b1, 3, 1'b0);
    tick();
    chk("drop_rd_data", 64'(bus.o_rd_data), 64'hAAAAAAAAAAAA);

    // Simultaneous dones: bank 1 full, writer on bank 0
    drive(1'b1, 7, 48'h123456789ABC, 1'b0, 1'b0, 0, 1'b0);
    tick();
    drive(1'b0, 0, 48'h0, 1'b1, 1'b0, 0, 1'b1);
    tick();
    chk("simul_wr_bank", 64'(bus.o_wr_bank), 64'h1);
    chk("simul_rd_bank", 64'(bus.o_rd_bank), 64'h0);
    chk("simul_full_cnt", 64'(bus.o_full_cnt), 64'h1);

    // Read together with rd_done uses the old bank
    drive(1'b0, 0, 48'h0, 1'b0, 1'b1, 7, 1'b1);
    tick();
    chk("rd_done_same_data", 64'(bus.o_rd_data), 64'h123456789ABC);
    chk("rd_done_same_valid", 64'(bus.o_rd_valid), 64'h1);
    chk("rd_done_same_ready", 64'(bus.o_rd_ready), 64'h0);

    // Random traffic with a reset in the middle
    for (int c = 0; c < 800; c++) begin
      rnd = {$urandom, $urandom};
      drive(($urandom_range(9, 0) < 7), int'($urandom_range(127, 0)), rnd[DW-1:0],
            ($urandom_range(19, 0) == 0), ($urandom_range(9, 0) < 6),
            int'($urandom_range(127, 0)), ($urandom_range(24, 0) == 0));
      tick();
      if (c == 400) begin
        rst_n = 1'b0;
        #2;
        model_reset();
        check_all();
        chk("midrst_wr_ready", 64'(bus.o_wr_ready), 64'h1);
        chk("midrst_rd_ready", 64'(bus.o_rd_ready), 64'h0);
        chk("midrst_full_cnt", 64'(bus.o_full_cnt), 64'h0);
        chk("midrst_rd_valid", 64'(bus.o_rd_valid), 64'h0);
        chk("midrst_banks", 64'({bus.o_wr_bank, bus.o_rd_bank}), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
